// File: rtl/id_ex_pipe_pkg.sv
// Shared constants for the ID/EX stage: control-word layout and hazard policies.
package id_ex_pipe_pkg;

  localparam int unsigned CTRL_W = 5;

  // Bit positions inside the {wb_en, mem_r_en, mem_w_en, b, s} control word.
  localparam int unsigned CTRL_WB_EN    = 4;
  localparam int unsigned CTRL_MEM_R_EN = 3;
  localparam int unsigned CTRL_MEM_W_EN = 2;
  localparam int unsigned CTRL_B        = 1;
  localparam int unsigned CTRL_S        = 0;

  // Hazard policy encodings for HAZARD_MODE.
  localparam int unsigned HAZARD_STALL_RAW = 0;
  localparam int unsigned HAZARD_LOAD_USE  = 1;

  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic b;
    logic s;
  } ctrl_t;

  // Payload width for a given set of field widths.
  function automatic int unsigned payload_width(input int unsigned exec_cmd_w,
                                                input int unsigned addr_w,
                                                input int unsigned data_w,
                                                input int unsigned shift_w,
                                                input int unsigned simm_w,
                                                input int unsigned status_w);
    return exec_cmd_w + addr_w + 2 * data_w + 1 + shift_w + simm_w + status_w;
  endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Combinational RAW hazard detector: compares ID sources with the EX and MEM
// destination shadows under the selected stall policy.
module id_hazard_detect
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned RF_ADDR_W   = 4,
  parameter int unsigned HAZARD_MODE = HAZARD_STALL_RAW
) (
  input  logic                 id_valid,
  input  logic [RF_ADDR_W-1:0] src_1,
  input  logic [RF_ADDR_W-1:0] src_2,
  input  logic                 two_src,
  input  logic                 ex_valid,
  input  logic                 ex_wb_en,
  input  logic                 ex_mem_r_en,
  input  logic [RF_ADDR_W-1:0] ex_dest,
  input  logic                 mem_valid,
  input  logic                 mem_wb_en,
  input  logic [RF_ADDR_W-1:0] mem_dest,
  output logic                 hazard
);

  logic ex_match;
  logic mem_match;

  // A stage matches when it will write a register the ID instruction reads.
  always_comb begin
    ex_match  = ex_valid & ex_wb_en &
                ((ex_dest == src_1) | (two_src & (ex_dest == src_2)));
    mem_match = mem_valid & mem_wb_en &
                ((mem_dest == src_1) | (two_src & (mem_dest == src_2)));
    if (HAZARD_MODE == HAZARD_LOAD_USE) begin
      // Forwarding covers ALU results; only a load in EX is not yet available.
      hazard = id_valid & ex_match & ex_mem_r_en;
    end else begin
      hazard = id_valid & (ex_match | mem_match);
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with MEM destination shadow, hazard stalling,
// branch flush, downstream back-pressure and a saturating stall counter.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RF_ADDR_W   = 4,
  parameter int unsigned EXEC_CMD_W  = 4,
  parameter int unsigned SHIFT_W     = 12,
  parameter int unsigned SIMM_W      = 24,
  parameter int unsigned STATUS_W    = 4,
  parameter int unsigned HAZARD_MODE = HAZARD_STALL_RAW,
  parameter int unsigned STALL_CNT_W = 16,
  localparam int unsigned PAYLOAD_W  = payload_width(EXEC_CMD_W, ADDR_W, DATA_W,
                                                     SHIFT_W, SIMM_W, STATUS_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [CTRL_W-1:0]      ctrl_in,
  input  logic [RF_ADDR_W-1:0]   dest_in,
  input  logic [RF_ADDR_W-1:0]   src_1,
  input  logic [RF_ADDR_W-1:0]   src_2,
  input  logic                   two_src,
  input  logic [PAYLOAD_W-1:0]   payload_in,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   ex_valid,
  output logic [CTRL_W-1:0]      ctrl_out,
  output logic [RF_ADDR_W-1:0]   dest_out,
  output logic [PAYLOAD_W-1:0]   payload_out,
  output logic                   stall_if,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic                 mem_valid_q;
  logic                 mem_wb_en_q;
  logic [RF_ADDR_W-1:0] mem_dest_q;
  logic                 hazard;
  ctrl_t                ex_ctrl;

  assign ex_ctrl = ctrl_t'(ctrl_out);

  id_hazard_detect #(
    .RF_ADDR_W   (RF_ADDR_W),
    .HAZARD_MODE (HAZARD_MODE)
  ) u_hazard (
    .id_valid    (id_valid),
    .src_1       (src_1),
    .src_2       (src_2),
    .two_src     (two_src),
    .ex_valid    (ex_valid),
    .ex_wb_en    (ex_ctrl.wb_en),
    .ex_mem_r_en (ex_ctrl.mem_r_en),
    .ex_dest     (dest_out),
    .mem_valid   (mem_valid_q),
    .mem_wb_en   (mem_wb_en_q),
    .mem_dest    (mem_dest_q),
    .hazard      (hazard)
  );

  // Hold upstream on a live hazard (a flush kills it instead) or when EX is blocked.
  always_comb begin
    stall_if = (hazard & ~flush) | ~ex_ready;
  end

  // Pipeline register, MEM shadow and stall counter; everything freezes without ex_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      ctrl_out    <= '0;
      dest_out    <= '0;
      payload_out <= '0;
      mem_valid_q <= 1'b0;
      mem_wb_en_q <= 1'b0;
      mem_dest_q  <= '0;
      stall_count <= '0;
    end else if (ex_ready) begin
      mem_valid_q <= ex_valid;
      mem_wb_en_q <= ex_ctrl.wb_en;
      mem_dest_q  <= dest_out;
      if (flush || hazard) begin
        ex_valid    <= 1'b0;
        ctrl_out    <= '0;
        dest_out    <= '0;
        payload_out <= '0;
        if (!flush && (stall_count != '1)) begin
          stall_count <= stall_count + 1'b1;
        end
      end else begin
        ex_valid    <= id_valid;
        ctrl_out    <= ctrl_in & {CTRL_W{id_valid}};
        dest_out    <= dest_in;
        payload_out <= payload_in;
      end
    end
  end

  // A flush while EX is blocked would be silently dropped.
  assert property (@(posedge clk) disable iff (!rst) !(flush && !ex_ready))
    else $error("flush asserted while ex_ready is low");

endmodule

// File: tb/tb_id_ex_pipe.sv
// Randomised and directed bench for id_ex_pipe: three instances (stall-on-RAW,
// load-use, and a 2-bit stall counter) share stimulus and are compared against
// a slot-history reference model.
module tb_id_ex_pipe;

  localparam int RW = 4;
  localparam int PW = 4 + 32 + 2 * 32 + 1 + 12 + 24 + 4;
  localparam int NI = 3;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [4:0]    ctrl_in;
  logic [RW-1:0] dest_in;
  logic [RW-1:0] src_1;
  logic [RW-1:0] src_2;
  logic          two_src;
  logic [PW-1:0] payload_in;
  logic          flush;
  logic          ex_ready;

  logic          vld [NI];
  logic [4:0]    ctl [NI];
  logic [RW-1:0] dst [NI];
  logic [PW-1:0] pay [NI];
  logic          stl [NI];
  logic [15:0]   sc0;
  logic [15:0]   sc1;
  logic [1:0]    sc2;

  int n_total;
  int n_bad;

  id_ex_pipe #(.HAZARD_MODE(0), .STALL_CNT_W(16)) u_m0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .ctrl_in(ctrl_in), .dest_in(dest_in),
    .src_1(src_1), .src_2(src_2), .two_src(two_src), .payload_in(payload_in),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(vld[0]), .ctrl_out(ctl[0]),
    .dest_out(dst[0]), .payload_out(pay[0]), .stall_if(stl[0]), .stall_count(sc0)
  );

  id_ex_pipe #(.HAZARD_MODE(1), .STALL_CNT_W(16)) u_m1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .ctrl_in(ctrl_in), .dest_in(dest_in),
    .src_1(src_1), .src_2(src_2), .two_src(two_src), .payload_in(payload_in),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(vld[1]), .ctrl_out(ctl[1]),
    .dest_out(dst[1]), .payload_out(pay[1]), .stall_if(stl[1]), .stall_count(sc1)
  );

  id_ex_pipe #(.HAZARD_MODE(0), .STALL_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .ctrl_in(ctrl_in), .dest_in(dest_in),
    .src_1(src_1), .src_2(src_2), .two_src(two_src), .payload_in(payload_in),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(vld[2]), .ctrl_out(ctl[2]),
    .dest_out(dst[2]), .payload_out(pay[2]), .stall_if(stl[2]), .stall_count(sc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // Reference model: the instruction slot sitting in EX and the one that moved on to MEM.
  typedef struct packed {
    logic          v;
    logic [4:0]    ctrl;
    logic [RW-1:0] dest;
    logic [PW-1:0] pay;
  } slot_t;

  slot_t ex_m  [NI];
  slot_t mem_m [NI];
  int    cnt_m [NI];
  int    cnt_max [NI] = '{65535, 65535, 3};
  int    mode_m  [NI] = '{0, 1, 0};

  task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit reads(input logic [RW-1:0] r);
    return (src_1 == r) || (two_src && (src_2 == r));
  endfunction

  function automatic bit model_haz(input int k);
    bit ex_hit;
    bit mem_hit;
    ex_hit  = ex_m[k].v && ex_m[k].ctrl[4] && reads(ex_m[k].dest);
    mem_hit = mem_m[k].v && mem_m[k].ctrl[4] && reads(mem_m[k].dest);
    if (!id_valid) return 1'b0;
    if (mode_m[k] == 1) return ex_hit && ex_m[k].ctrl[3];
    return ex_hit || mem_hit;
  endfunction

  function automatic int dut_count(input int k);
    if (k == 0) return int'(sc0);
    if (k == 1) return int'(sc1);
    return int'(sc2);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      ex_m[k]  = '0;
      mem_m[k] = '0;
      cnt_m[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit haz;
    for (int k = 0; k < NI; k++) begin
      if (ex_ready) begin
        haz      = model_haz(k);
        mem_m[k] = ex_m[k];
        if (flush) begin
          ex_m[k] = '0;
        end else if (haz) begin
          ex_m[k] = '0;
          if (cnt_m[k] < cnt_max[k]) cnt_m[k]++;
        end else begin
          ex_m[k] = {id_valid, ctrl_in & {5{id_valid}}, dest_in, payload_in};
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("ex_valid[%0d]", k), vld[k], ex_m[k].v);
      check_eq($sformatf("ctrl_out[%0d]", k), ctl[k], ex_m[k].ctrl);
      check_eq($sformatf("dest_out[%0d]", k), dst[k], ex_m[k].dest);
      check_eq($sformatf("payload_out[%0d]", k), pay[k], ex_m[k].pay);
      check_eq($sformatf("stall_count[%0d]", k), dut_count(k), cnt_m[k]);
      check_eq($sformatf("stall_if[%0d]", k), stl[k], (model_haz(k) && !flush) || !ex_ready);
    end
  endtask

  // One clock: check away from the edge, then advance the model with the edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] c, input logic [RW-1:0] d,
                        input logic [RW-1:0] s1, input logic [RW-1:0] s2, input logic two,
                        input logic fl, input logic rdy);
    logic [159:0] r;
    r          = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    id_valid   = v;
    ctrl_in    = c;
    dest_in    = d;
    src_1      = s1;
    src_2      = s2;
    two_src    = two;
    payload_in = r[PW-1:0];
    flush      = fl;
    ex_ready   = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    set_in(1'b0, 5'd0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [PW-1:0] snap;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b0;
    set_in(1'b0, 5'd0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Mode 0 RAW: ADD r3 ; SUB r4,r3,r1 -> two bubbles, SUB in EX on the 3rd edge.
    do_reset();
    set_in(1'b1, 5'b10000, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    set_in(1'b1, 5'b10000, 4'd4, 4'd3, 4'd1, 1'b1, 1'b0, 1'b1);
    repeat (3) cycle();
    check_eq("raw_cnt_m0", sc0, 2);
    check_eq("raw_ex_m0", {vld[0], dst[0]}, {1'b1, 4'd4});
    check_eq("raw_cnt_m1", sc1, 0);

    // Mode 1 load-use: LDR r2 ; ADD r5,r2,r2 -> exactly one bubble.
    do_reset();
    set_in(1'b1, 5'b11000, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    set_in(1'b1, 5'b10000, 4'd5, 4'd2, 4'd2, 1'b1, 1'b0, 1'b1);
    repeat (2) cycle();
    check_eq("lu_cnt_m1", sc1, 1);
    check_eq("lu_ex_m1", {vld[1], dst[1]}, {1'b1, 4'd5});

    // src_2 only counts when two_src is set.
    do_reset();
    set_in(1'b1, 5'b10000, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    set_in(1'b1, 5'b10000, 4'd9, 4'd1, 4'd7, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("one_src_stall_m0", stl[0], 1'b0);
    two_src = 1'b1;
    #1;
    check_eq("two_src_stall_m0", stl[0], 1'b1);
    check_eq("two_src_stall_m1", stl[1], 1'b0);
    cycle();

    // Flush beats a pending hazard; the following instruction loads normally.
    do_reset();
    set_in(1'b1, 5'b10000, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    set_in(1'b1, 5'b10000, 4'd4, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1);
    #1;
    check_eq("flush_stall_m0", stl[0], 1'b0);
    cycle();
    check_eq("flush_cnt_m0", sc0, 0);
    check_eq("flush_bubble_m0", vld[0], 1'b0);
    set_in(1'b1, 5'b10000, 4'd6, 4'd8, 4'd8, 1'b0, 1'b0, 1'b1);
    cycle();
    check_eq("after_flush_m0", {vld[0], dst[0]}, {1'b1, 4'd6});

    // Back-pressure: three blocked cycles freeze EX and hold IF.
    do_reset();
    set_in(1'b1, 5'b10101, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    snap = pay[0];
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'b10000, 4'd8, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
      #1;
      check_eq("bp_stall_m0", stl[0], 1'b1);
      cycle();
      check_eq("bp_payload_m0", pay[0], snap);
      check_eq("bp_dest_m0", {vld[0], ctl[0], dst[0]}, {1'b1, 5'b10101, 4'd3});
    end

    // Self-dependent instruction re-presented: six hazard cycles in nine edges.
    do_reset();
    set_in(1'b1, 5'b10000, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0, 1'b1);
    repeat (9) cycle();
    check_eq("sat_cnt_w2", sc2, 3);
    check_eq("sat_cnt_w16", sc0, 6);

    // Random traffic with a reset in the middle.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic rdy;
      if (i == 1000) do_reset();
      rdy = ($urandom_range(0, 4) != 0);
      set_in($urandom_range(0, 3) != 0, 5'($urandom()), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom()),
             rdy && ($urandom_range(0, 7) == 0), rdy);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
